// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// through a single binary-add-plus-6 correction cell, with start/busy/done handshake.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg;
    logic               sub_reg;
    logic [W-1:0]       a_reg, b_reg;
    logic [W-1:0]       acc_reg, acc_next;
    logic [W-1:0]       sum_reg;
    logic               cout_reg;
    logic               invalid_reg;

    logic [DIGITS-1:0]  nib_bad;
    logic               operand_bad;
    logic               accept;
    logic               last_digit;
    logic [3:0]         a_dig, b_dig, bd, nibble;
    logic [4:0]         t, t_adj;
    logic               digit_carry;

    // Validation looks at the live inputs because it decides the transition on the start edge.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_check
            assign nib_bad[gi] = (a[4*gi +: 4] > 4'd9) || (b[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign operand_bad = |nib_bad;
    assign accept      = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_digit  = (idx_reg == IDX_W'(DIGITS - 1));

    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                a_dig = a_reg[4*i +: 4];
                b_dig = b_reg[4*i +: 4];
            end
        end
    end

    // Subtraction adds the nines' complement of b; the initial carry (~borrow) completes it.
    always_comb begin
        bd          = sub_reg ? (4'd9 - b_dig) : b_dig;
        t           = {1'b0, a_dig} + {1'b0, bd} + {4'b0000, carry_reg};
        t_adj       = t + 5'd6;
        digit_carry = (t > 5'd9);
        nibble      = digit_carry ? t_adj[3:0] : t[3:0];
    end

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_acc
            assign acc_next[4*gi +: 4] = (idx_reg == IDX_W'(gi)) ? nibble : acc_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) state_next = operand_bad ? DONE : RUN;
                else        state_next = IDLE;
            end
            RUN: begin
                if (last_digit) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            carry_reg   <= 1'b0;
            sub_reg     <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            sum_reg     <= '0;
            cout_reg    <= 1'b0;
            invalid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                sub_reg   <= sub;
                carry_reg <= sub ^ cin;
                idx_reg   <= '0;
                if (operand_bad) begin
                    sum_reg     <= '0;
                    cout_reg    <= 1'b0;
                    invalid_reg <= 1'b1;
                end
            end else if (state_reg == RUN) begin
                acc_reg   <= acc_next;
                carry_reg <= digit_carry;
                idx_reg   <= idx_reg + 1'b1;
                // Publish only the complete result so sum never shows partial digits.
                if (last_digit) begin
                    sum_reg     <= acc_next;
                    cout_reg    <= digit_carry;
                    invalid_reg <= 1'b0;
                end
            end
        end
    end

    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign sum     = sum_reg;
    assign cout    = cout_reg;
    assign invalid = invalid_reg;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub at DIGITS=1, 4 and 8: vector table, handshake corner
// sequences, async reset abort and random ops against an integer reference model.
module tb_bcd_serial_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a_in = '0, b_in = '0;
    logic        sub_in = 1'b0, cin_in = 1'b0;
    logic        start1 = 1'b0, start4 = 1'b0, start8 = 1'b0;

    logic        busy1, done1, cout1, inv1;
    logic [3:0]  sum1;
    logic        busy4, done4, cout4, inv4;
    logic [15:0] sum4;
    logic        busy8, done8, cout8, inv8;
    logic [31:0] sum8;

    always #5 clk = ~clk;

    bcd_serial_addsub #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub_in), .a(a_in[3:0]), .b(b_in[3:0]),
        .cin(cin_in), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .invalid(inv1));
    bcd_serial_addsub #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub_in), .a(a_in[15:0]), .b(b_in[15:0]),
        .cin(cin_in), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .invalid(inv4));
    bcd_serial_addsub #(.DIGITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub_in), .a(a_in), .b(b_in),
        .cin(cin_in), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .invalid(inv8));

    int          sel = 4;
    logic        busy_s, done_s, cout_s, inv_s;
    logic [31:0] sum_s;

    always_comb begin
        busy_s = busy4; done_s = done4; cout_s = cout4; inv_s = inv4; sum_s = {16'h0, sum4};
        if (sel == 1) begin
            busy_s = busy1; done_s = done1; cout_s = cout1; inv_s = inv1; sum_s = {28'h0, sum1};
        end else if (sel == 8) begin
            busy_s = busy8; done_s = done8; cout_s = cout8; inv_s = inv8; sum_s = sum8;
        end
    end

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        inv;
        int          lat;
        int          busy;
        longint      start_cyc;
    } exp_t;

    typedef struct {
        int          d;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] es;
        logic        eco;
        logic        einv;
    } vec_t;

    exp_t   sb[$];
    vec_t   tbl[$];
    int     checks = 0;
    int     fails  = 0;
    longint cyc    = 0;
    int     busy_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest outstanding expectation.
    logic [31:0] sum_prev  = '0;
    logic        busy_prev = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (busy_s) busy_cnt++;
        if (busy_s && busy_prev) check("sum_stable", sum_s, sum_prev);
        if (done_s === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {31'b0, done_s}, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("op d=%0d sum=%h cout=%b invalid=%b latency=%0d busy=%0d",
                         sel, sum_s, cout_s, inv_s, int'(cyc - e.start_cyc) + 1, busy_cnt);
                check("sum", sum_s, e.sum);
                check("cout", {31'b0, cout_s}, {31'b0, e.cout});
                check("invalid", {31'b0, inv_s}, {31'b0, e.inv});
                check("latency", 32'(int'(cyc - e.start_cyc) + 1), 32'(e.lat));
                check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
            end
            busy_cnt = 0;
        end
        sum_prev  = sum_s;
        busy_prev = busy_s;
    end

    function automatic longint bcd2int(input logic [31:0] v, input int d);
        longint r = 0;
        for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input longint v, input int d);
        logic [31:0] r = '0;
        longint x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model(input int d, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic c, output logic [31:0] r, output logic co);
        longint m = 1;
        longint t;
        for (int i = 0; i < d; i++) m = m * 10;
        if (!s) begin
            t  = bcd2int(a, d) + bcd2int(b, d) + longint'(c);
            co = (t >= m);
            if (co) t = t - m;
        end else begin
            t  = bcd2int(a, d) - bcd2int(b, d) - longint'(c);
            co = (t >= 0);
            if (!co) t = t + m;
        end
        r = int2bcd(t, d);
    endtask

    function automatic logic [31:0] rand_bcd(input int d);
        logic [31:0] v = '0;
        for (int i = 0; i < d; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Drives one start pulse from the current negedge and queues its expected result.
    task automatic issue(input int d, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [31:0] es, input logic eco, input logic einv);
        exp_t e;
        sel = d; a_in = a; b_in = b; sub_in = s; cin_in = c;
        e.sum = es; e.cout = eco; e.inv = einv;
        e.lat = einv ? 1 : d + 1;
        e.busy = einv ? 0 : d;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
        start1 = (d == 1); start4 = (d == 4); start8 = (d == 8);
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0; start8 = 1'b0;
        a_in = $urandom; b_in = $urandom; sub_in = 1'($urandom); cin_in = 1'($urandom);
    endtask

    task automatic start_op(input int d, input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic c, input logic [31:0] es, input logic eco, input logic einv);
        @(negedge clk);
        issue(d, s, a, b, c, es, eco, einv);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL done_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        co;
        int          d;
        logic        s, c;
        logic [31:0] ra, rb;

        tbl.push_back(vec_t'{4, 1'b0, 32'h1234,     32'h5678,     1'b0, 32'h6912,     1'b0, 1'b0});
        tbl.push_back(vec_t'{4, 1'b0, 32'h9999,     32'h0001,     1'b0, 32'h0000,     1'b1, 1'b0});
        tbl.push_back(vec_t'{4, 1'b0, 32'h0999,     32'h0000,     1'b1, 32'h1000,     1'b0, 1'b0});
        tbl.push_back(vec_t'{4, 1'b1, 32'h5000,     32'h1234,     1'b0, 32'h3766,     1'b1, 1'b0});
        tbl.push_back(vec_t'{4, 1'b1, 32'h1234,     32'h5000,     1'b0, 32'h6234,     1'b0, 1'b0});
        tbl.push_back(vec_t'{4, 1'b1, 32'h0000,     32'h0000,     1'b1, 32'h9999,     1'b0, 1'b0});
        tbl.push_back(vec_t'{4, 1'b0, 32'h12A4,     32'h0001,     1'b0, 32'h0000,     1'b0, 1'b1});
        tbl.push_back(vec_t'{4, 1'b0, 32'h0000,     32'h0001,     1'b0, 32'h0001,     1'b0, 1'b0});
        tbl.push_back(vec_t'{4, 1'b1, 32'h0003,     32'h00B0,     1'b0, 32'h0000,     1'b0, 1'b1});
        tbl.push_back(vec_t'{1, 1'b0, 32'h4,        32'h5,        1'b0, 32'h9,        1'b0, 1'b0});
        tbl.push_back(vec_t'{1, 1'b0, 32'h9,        32'h1,        1'b0, 32'h0,        1'b1, 1'b0});
        tbl.push_back(vec_t'{1, 1'b0, 32'h9,        32'h0,        1'b1, 32'h0,        1'b1, 1'b0});
        tbl.push_back(vec_t'{1, 1'b1, 32'h5,        32'h1,        1'b0, 32'h4,        1'b1, 1'b0});
        tbl.push_back(vec_t'{1, 1'b1, 32'h1,        32'h5,        1'b0, 32'h6,        1'b0, 1'b0});
        tbl.push_back(vec_t'{1, 1'b1, 32'h0,        32'h0,        1'b1, 32'h9,        1'b0, 1'b0});
        tbl.push_back(vec_t'{8, 1'b0, 32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0});
        tbl.push_back(vec_t'{8, 1'b0, 32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0});
        tbl.push_back(vec_t'{8, 1'b0, 32'h09999999, 32'h00000000, 1'b1, 32'h10000000, 1'b0, 1'b0});
        tbl.push_back(vec_t'{8, 1'b1, 32'h50000000, 32'h12345678, 1'b0, 32'h37654322, 1'b1, 1'b0});
        tbl.push_back(vec_t'{8, 1'b1, 32'h12345678, 32'h50000000, 1'b0, 32'h62345678, 1'b0, 1'b0});
        tbl.push_back(vec_t'{8, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 32'h99999999, 1'b0, 1'b0});
        tbl.push_back(vec_t'{8, 1'b0, 32'h9A000000, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b1});

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_sum4", {16'h0, sum4}, 32'h0);
        check("rst_cout4", {31'b0, cout4}, 32'h0);
        check("rst_invalid4", {31'b0, inv4}, 32'h0);
        check("rst_busy4", {31'b0, busy4}, 32'h0);
        check("rst_done4", {31'b0, done4}, 32'h0);
        check("rst_sum8", sum8, 32'h0);
        check("rst_sum1", {28'h0, sum1}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            start_op(tbl[i].d, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].c,
                     tbl[i].es, tbl[i].eco, tbl[i].einv);
            wait_idle(tbl[i].d + 10);
        end

        // Start held on the DONE cycle: second op must begin immediately.
        start_op(4, 1'b0, 32'h0001, 32'h0002, 1'b0, 32'h0003, 1'b0, 1'b0);
        for (int i = 0; i < 20 && done_s !== 1'b1; i++) @(negedge clk);
        check("b2b_done_seen", {31'b0, done_s}, 32'h1);
        issue(4, 1'b0, 32'h4321, 32'h1111, 1'b0, 32'h5432, 1'b0, 1'b0);
        wait_idle(20);

        // Start pulsed mid-RUN must be ignored.
        start_op(4, 1'b0, 32'h1234, 32'h5678, 1'b0, 32'h6912, 1'b0, 1'b0);
        @(negedge clk);
        a_in = 32'h9999; b_in = 32'h9999; sub_in = 1'b1; cin_in = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_idle(20);
        repeat (8) @(negedge clk);

        // Async reset while idx==2 aborts with no done afterwards.
        start_op(4, 1'b0, 32'h2222, 32'h3333, 1'b0, 32'h5555, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_sum", {16'h0, sum4}, 32'h0);
        check("abort_cout", {31'b0, cout4}, 32'h0);
        check("abort_invalid", {31'b0, inv4}, 32'h0);
        check("abort_busy", {31'b0, busy4}, 32'h0);
        check("abort_done", {31'b0, done4}, 32'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        busy_cnt = 0;
        repeat (8) @(negedge clk);
        start_op(4, 1'b1, 32'h0100, 32'h0001, 1'b0, 32'h0099, 1'b1, 1'b0);
        wait_idle(20);

        // Random valid operands against the integer model.
        for (int n = 0; n < 60; n++) begin
            d  = (n < 36) ? 4 : ((n < 48) ? 8 : 1);
            s  = 1'($urandom);
            c  = 1'($urandom);
            ra = rand_bcd(d);
            rb = rand_bcd(d);
            model(d, s, ra, rb, c, r, co);
            start_op(d, s, ra, rb, c, r, co, 1'b0);
            wait_idle(d + 10);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
